// File: rtl/elev_pkg.sv
// Shared state encoding and call-mask helpers for the SCAN elevator controller.
package elev_pkg;

  localparam int STATE_W = 2;
  localparam int MASK_W  = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2,
    DOOR    = 2'd3
  } state_t;

  // True when any call bit lies strictly above floor flr.
  function automatic logic any_above(input logic [MASK_W-1:0] mask, input logic [3:0] flr);
    logic [MASK_W-1:0] m;
    m = {MASK_W{1'b1}} << flr;
    m = m << 1;
    return |(mask & m);
  endfunction

  // True when any call bit lies strictly below floor flr.
  function automatic logic any_below(input logic [MASK_W-1:0] mask, input logic [3:0] flr);
    logic [MASK_W-1:0] m;
    m = ~({MASK_W{1'b1}} << flr);
    return |(mask & m);
  endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter used for both travel and door dwell; stops at zero.
module elev_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_hold,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!i_hold && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN (collective) elevator controller for FLOORS floors.
// Optional door_hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_scan_ctrl
  import elev_pkg::*;
#(
  parameter  int FLOORS  = 4,
  parameter  int MOVE_CY = 50,
  parameter  int DOOR_CY = 100,
  localparam int FLR_W   = $clog2(FLOORS)
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [FLOORS-1:0] hall_req,
  input  logic [FLOORS-1:0] cab_req,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  output logic [FLR_W-1:0]  floor,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  localparam int TMR_MAX = (MOVE_CY > DOOR_CY) ? MOVE_CY : DOOR_CY;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] MOVE_LOAD = TMR_W'(MOVE_CY - 1);
  localparam logic [TMR_W-1:0] DOOR_LOAD = TMR_W'(DOOR_CY - 1);
  localparam logic [FLR_W-1:0] TOP_FLR   = FLR_W'(FLOORS - 1);

  state_t            r_state, w_state_next;
  logic [FLR_W-1:0]  r_floor, w_floor_next, w_flr_step;
  logic              r_dir_up, w_dir_next;
  logic [FLOORS-1:0] r_pending, w_req, w_calls, w_served, w_here, w_adj;
  logic              w_above, w_below, w_at_end;
  logic              w_tmr_load, w_tmr_zero, w_tmr_hold;
  logic [TMR_W-1:0]  w_tmr_val;

  assign w_req      = hall_req | cab_req;
  assign w_calls    = r_pending | w_req;
  assign w_here     = FLOORS'(1) << r_floor;
  assign w_flr_step = (r_state == MOVE_UP) ? (r_floor + 1'b1) : (r_floor - 1'b1);
  assign w_adj      = FLOORS'(1) << w_flr_step;
  assign w_above    = any_above(MASK_W'(w_calls), 4'(r_floor));
  assign w_below    = any_below(MASK_W'(w_calls), 4'(r_floor));
  assign w_at_end   = (r_state == MOVE_UP) ? (r_floor == TOP_FLR) : (r_floor == '0);

`ifdef ELEV_DOOR_HOLD_EN
  assign w_tmr_hold = (r_state == DOOR) && door_hold;
`else
  assign w_tmr_hold = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_floor_next = r_floor;
    w_dir_next   = r_dir_up;
    w_served     = '0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = MOVE_LOAD;
    case (r_state)
      IDLE: begin
        if (|(w_calls & w_here)) begin
          w_state_next = DOOR;
          w_served     = w_here;
          w_tmr_load   = 1'b1;
          w_tmr_val    = DOOR_LOAD;
        end else if (w_above) begin
          w_state_next = MOVE_UP;
          w_dir_next   = 1'b1;
          w_tmr_load   = 1'b1;
        end else if (w_below) begin
          w_state_next = MOVE_DN;
          w_dir_next   = 1'b0;
          w_tmr_load   = 1'b1;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (w_tmr_zero) begin
          // Travel always targets a latched call, so the end guard only keeps floor in range.
          if (w_at_end) begin
            w_state_next = IDLE;
          end else begin
            w_floor_next = w_flr_step;
            w_tmr_load   = 1'b1;
            if (|(w_calls & w_adj)) begin
              w_state_next = DOOR;
              w_served     = w_adj;
              w_tmr_val    = DOOR_LOAD;
            end
          end
        end
      end
      DOOR: begin
        w_served = w_here;
        if (|(w_req & w_here)) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = DOOR_LOAD;
        end else if (w_tmr_zero && !w_tmr_hold) begin
          if (r_dir_up ? w_above : w_below) begin
            w_state_next = r_dir_up ? MOVE_UP : MOVE_DN;
            w_tmr_load   = 1'b1;
          end else if (r_dir_up ? w_below : w_above) begin
            w_state_next = r_dir_up ? MOVE_DN : MOVE_UP;
            w_dir_next   = ~r_dir_up;
            w_tmr_load   = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_floor   <= '0;
      r_dir_up  <= 1'b1;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_floor   <= w_floor_next;
      r_dir_up  <= w_dir_next;
      r_pending <= w_calls & ~w_served;
    end
  end

  elev_timer #(.W(TMR_W)) u_timer (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_hold     (w_tmr_hold),
    .o_zero     (w_tmr_zero)
  );

  assign floor     = r_floor;
  assign dir_up    = r_dir_up;
  assign moving    = (r_state == MOVE_UP) || (r_state == MOVE_DN);
  assign door_open = (r_state == DOOR);
  assign pending   = r_pending;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (FLOORS=4, MOVE_CY=50, DOOR_CY=100, 20 ns clock).
module tb_elevator_scan_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [3:0] hall_req = '0;
  logic [3:0] cab_req  = '0;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif
  logic [1:0] floor;
  logic       dir_up, moving, door_open;
  logic [3:0] pending;

  int   n_cmp = 0;
  int   n_err = 0;
  int   open_cnt [4];
  int   snap [4];
  logic door_prev = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  elevator_scan_ctrl #(.FLOORS(4), .MOVE_CY(50), .DOOR_CY(100)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .hall_req  (hall_req),
    .cab_req   (cab_req),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  // Count door openings per floor.
  always @(negedge CLOCK_50) begin
    if (door_open && !door_prev) open_cnt[floor] <= open_cnt[floor] + 1;
    door_prev <= door_open;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pulse(input logic [3:0] h, input logic [3:0] c);
    $display("[%0t] req hall=%b cab=%b at floor %0d", $time, h, c, floor);
    hall_req = h;
    cab_req  = c;
    @(negedge CLOCK_50);
    hall_req = '0;
    cab_req  = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) snap[i] = 0;

    // Reset state
    step(3);
    check_eq("rst_floor", 32'(floor), 0);
    check_eq("rst_dir", 32'(dir_up), 1);
    check_eq("rst_moving", 32'(moving), 0);
    check_eq("rst_door", 32'(door_open), 0);
    check_eq("rst_pending", 32'(pending), 0);
    RESET_N = 1'b1;
    step(2);

    // Trip up two floors
    pulse(4'b0100, 4'b0000);
    check_eq("t2_moving", 32'(moving), 1);
    check_eq("t2_pending", 32'(pending), 32'h4);
    step(49);
    check_eq("t2_floor_c50", 32'(floor), 0);
    step(1);
    check_eq("t2_floor1", 32'(floor), 1);
    step(49);
    check_eq("t2_floor_c100", 32'(floor), 1);
    step(1);
    check_eq("t2_floor2", 32'(floor), 2);
    check_eq("t2_door", 32'(door_open), 1);
    check_eq("t2_pend_clr", 32'(pending), 0);
    step(99);
    check_eq("t2_door_end", 32'(door_open), 1);
    step(1);
    check_eq("t2_door_closed", 32'(door_open), 0);
    check_eq("t2_idle", 32'(moving), 0);

    // Reset mid-move
    pulse(4'b0001, 4'b0000);
    check_eq("t1_moving", 32'(moving), 1);
    check_eq("t1_dir", 32'(dir_up), 0);
    step(9);
    pulse(4'b0000, 4'b1000);
    step(9);
    check_eq("t1_pend_pre", 32'(pending), 32'h9);
    $display("[%0t] async reset asserted", $time);
    RESET_N = 1'b0;
    #1;
    check_eq("t1_floor", 32'(floor), 0);
    check_eq("t1_pending", 32'(pending), 0);
    check_eq("t1_moving_rst", 32'(moving), 0);
    check_eq("t1_dir_rst", 32'(dir_up), 1);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    step(60);
    check_eq("t1_no_retain", 32'(pending), 0);
    check_eq("t1_still_idle", 32'(moving), 0);

    // SCAN order
    for (int i = 0; i < 4; i++) snap[i] = open_cnt[i];
    pulse(4'b0000, 4'b1000);
    step(50);
    check_eq("t3_floor1", 32'(floor), 1);
    pulse(4'b0001, 4'b0000);
    check_eq("t3_pend", 32'(pending), 32'h9);
    step(99);
    check_eq("t3_floor3", 32'(floor), 3);
    check_eq("t3_door3", 32'(door_open), 1);
    check_eq("t3_pend3", 32'(pending), 32'h1);
    step(100);
    check_eq("t3_rev_moving", 32'(moving), 1);
    check_eq("t3_rev_dir", 32'(dir_up), 0);
    step(150);
    check_eq("t3_floor0", 32'(floor), 0);
    check_eq("t3_door0", 32'(door_open), 1);
    check_eq("t3_pend0", 32'(pending), 0);
    step(100);
    check_eq("t3_closed", 32'(door_open), 0);
    check_eq("t3_no_open2", 32'(open_cnt[2] - snap[2]), 0);

    // Pass-through pickup
    pulse(4'b0000, 4'b1000);
    check_eq("t4_dir", 32'(dir_up), 1);
    step(59);
    pulse(4'b0100, 4'b0000);
    step(40);
    check_eq("t4_floor2", 32'(floor), 2);
    check_eq("t4_door2", 32'(door_open), 1);
    check_eq("t4_pend2", 32'(pending), 32'h8);
    step(100);
    check_eq("t4_resume", 32'(moving), 1);
    step(50);
    check_eq("t4_floor3", 32'(floor), 3);
    check_eq("t4_door3", 32'(door_open), 1);
    step(100);
    check_eq("t4_closed", 32'(door_open), 0);
    check_eq("t4_idle", 32'(moving), 0);

    // Re-open
    pulse(4'b0100, 4'b0000);
    check_eq("t5_dir", 32'(dir_up), 0);
    step(50);
    check_eq("t5_door", 32'(door_open), 1);
    step(80);
    pulse(4'b0000, 4'b0100);
    check_eq("t5_pend", 32'(pending), 0);
    step(20);
    check_eq("t5_extended", 32'(door_open), 1);
    step(79);
    check_eq("t5_last_open", 32'(door_open), 1);
    step(1);
    check_eq("t5_closed", 32'(door_open), 0);
    check_eq("t5_floor", 32'(floor), 2);

    // Simultaneous requests
    for (int i = 0; i < 4; i++) snap[i] = open_cnt[i];
    pulse(4'b1000, 4'b1001);
    check_eq("t6_pend", 32'(pending), 32'h9);
    check_eq("t6_dir", 32'(dir_up), 1);
    step(50);
    check_eq("t6_floor3", 32'(floor), 3);
    check_eq("t6_pend3", 32'(pending), 32'h1);
    step(100);
    check_eq("t6_down", 32'(dir_up), 0);
    step(150);
    check_eq("t6_floor0", 32'(floor), 0);
    check_eq("t6_door0", 32'(door_open), 1);
`ifdef ELEV_DOOR_HOLD_EN
    $display("[%0t] door_hold high for 300 cycles", $time);
    door_hold = 1'b1;
    step(300);
    check_eq("t6_hold_open", 32'(door_open), 1);
    door_hold = 1'b0;
`endif
    step(99);
    check_eq("t6_door_end", 32'(door_open), 1);
    step(1);
    check_eq("t6_closed", 32'(door_open), 0);
    check_eq("t6_once3", 32'(open_cnt[3] - snap[3]), 1);
    check_eq("t6_once0", 32'(open_cnt[0] - snap[0]), 1);
    check_eq("t6_none12", 32'((open_cnt[1] - snap[1]) + (open_cnt[2] - snap[2])), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
